// File: rtl/mpu_seq_core_if.sv
// Program-memory read bus for mpu_seq_core.
//   mem_req   : core requests a read at mem_addr
//   mem_addr  : read address (the core's pc)
//   mem_ack   : read data valid this cycle (may arrive with the request)
//   mem_rdata : read data, taken when mem_req & mem_ack
// master = core side, slave = memory side.
interface mpu_seq_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 12
);
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/mpu_seq_core.sv
// Multi-cycle micro-processing core: fetches an instruction byte plus
// 0..3 operand bytes over a req/ack bus, then runs EXEC and WB.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   halt_in            async level halt request (synchronised internally)
//   mem                program-memory bus (master side)
//   phase, pc, halted  current phase encoding, program counter, frozen flag
//   flag_z, flag_c     ALU zero / carry-borrow flags
//   dbg_sel, dbg_data  combinational register peek (0 for missing regs)
module mpu_seq_core #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8,
  parameter int PC_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_in,
  mpu_seq_core_if.master    mem,
  output logic [2:0]        phase,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [2:0] PH_FETCH   = 3'b000;
  localparam logic [2:0] PH_DECODE  = 3'b001;
  localparam logic [2:0] PH_OPERAND = 3'b010;
  localparam logic [2:0] PH_EXEC    = 3'b101;
  localparam logic [2:0] PH_WB      = 3'b110;
  localparam logic [2:0] PH_HALT    = 3'b111;

  typedef logic [DATA_W-1:0] word_t;

  logic [2:0]                     phase_q, phase_d, saved_q, saved_d, nxt;
  logic [PC_W-1:0]                pc_q, pc_d;
  logic [7:0]                     instr_q, instr_d, b1_q, b1_d, b2_q, b2_d;
  logic [1:0]                     opcnt_q, opcnt_d;
  word_t                          res_q, res_d;
  logic [REG_CNT-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [7:0][DATA_W-1:0]         regs_x;
  logic                           fz_q, fz_d, fc_q, fc_d;
  logic                           hs1_q, hs1_d, hs_q, hs_d;

  logic [1:0]    n;
  logic [2:0]    op, rd;
  word_t         a, b, alu_r;
  logic          alu_c, req, acked, step;
  logic [DATA_W:0] sum, dif;

  assign n  = instr_q[7:6];
  assign op = instr_q[5:3];
  assign rd = instr_q[2:0];

  assign req          = (phase_q == PH_FETCH) || (phase_q == PH_OPERAND);
  assign mem.mem_req  = rst_n & req;   // HALTED is its own phase, so req is already low there
  assign mem.mem_addr = pc_q;
  assign acked        = req & mem.mem_ack;

  // Zero-padded view of the register file: indices >= REG_CNT read as 0.
  always_comb begin
    regs_x = '0;
    for (int i = 0; i < REG_CNT; i++) regs_x[i] = regs_q[i];
  end

  assign dbg_data = regs_x[dbg_sel];
  assign a        = regs_x[rd];
  assign b        = (n == 2'd0) ? regs_x[0] : word_t'(b1_q);

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    alu_r = sum[DATA_W-1:0];
    alu_c = sum[DATA_W];
    case (op)
      3'd1: begin alu_r = dif[DATA_W-1:0];          alu_c = dif[DATA_W]; end
      3'd2: begin alu_r = a & b;                     alu_c = 1'b0;        end
      3'd3: begin alu_r = a | b;                     alu_c = 1'b0;        end
      3'd4: begin alu_r = a ^ b;                     alu_c = 1'b0;        end
      3'd5: begin alu_r = b;                         alu_c = fc_q;        end
      3'd6: begin alu_r = {a[DATA_W-2:0], 1'b0};     alu_c = a[DATA_W-1]; end
      3'd7: begin alu_r = {1'b0, a[DATA_W-1:1]};     alu_c = a[0];        end
      default: ;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    saved_d = saved_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    opcnt_d = opcnt_q;
    res_d   = res_q;
    regs_d  = regs_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    hs1_d   = halt_in;
    hs_d    = hs1_q;
    nxt     = phase_q;
    step    = 1'b0;   // a phase step happens this edge; halt may only land on one

    case (phase_q)
      PH_FETCH: if (acked) begin
        instr_d = mem.mem_rdata[7:0];
        pc_d    = pc_q + 1'b1;
        nxt     = PH_DECODE;
        step    = 1'b1;
      end
      PH_DECODE: begin
        opcnt_d = n;
        nxt     = (n == 2'd0) ? PH_EXEC : PH_OPERAND;
        step    = 1'b1;
      end
      PH_OPERAND: if (acked) begin
        // opcnt counts down from N, so the first byte arrives with opcnt == N
        if (opcnt_q == n)                b1_d = mem.mem_rdata[7:0];
        else if (opcnt_q == n - 2'd1)    b2_d = mem.mem_rdata[7:0];
        pc_d    = pc_q + 1'b1;
        opcnt_d = opcnt_q - 2'd1;
        nxt     = (opcnt_q == 2'd1) ? PH_EXEC : PH_OPERAND;
        step    = 1'b1;
      end
      PH_EXEC: begin
        case (n)
          2'd2: pc_d = PC_W'({b1_q, b2_q});
          2'd3: ;
          default: begin
            res_d = alu_r;
            fc_d  = alu_c;
            fz_d  = (alu_r == '0);
          end
        endcase
        nxt  = PH_WB;
        step = 1'b1;
      end
      PH_WB: begin
        if (n <= 2'd1)
          for (int i = 0; i < REG_CNT; i++)
            if (rd == 3'(i)) regs_d[i] = res_q;
        nxt  = PH_FETCH;
        step = 1'b1;
      end
      PH_HALT: if (!hs_q) phase_d = saved_q;
      default: phase_d = PH_FETCH;
    endcase

    // The step's side effects always commit; halt only redirects the phase.
    if (step) begin
      if (hs_q) begin
        saved_d = nxt;
        phase_d = PH_HALT;
      end else begin
        phase_d = nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_FETCH;
      saved_q <= PH_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      opcnt_q <= '0;
      res_q   <= '0;
      regs_q  <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      hs1_q   <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      saved_q <= saved_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      opcnt_q <= opcnt_d;
      res_q   <= res_d;
      regs_q  <= regs_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      hs1_q   <= hs1_d;
      hs_q    <= hs_d;
    end
  end

  assign phase  = phase_q;
  assign pc     = pc_q;
  assign halted = (phase_q == PH_HALT);
  assign flag_z = fz_q;
  assign flag_c = fc_q;
endmodule

// File: doc/mpu_seq_core.md
Name: mpu_seq_core

Overview:
- Parametrised multi-cycle micro-processing core; next generation of the fixed 8-bit phase-counter MPU.
- Adds:
  - a generic register file and program counter;
  - a memory fetch handshake;
  - variable operand count per instruction;
  - an ALU with flags;
  - synchronised halt/resume that preserves the interrupted phase.
- Sits between the TT top-level pin wrapper (memory bus on uio, halt/debug on ui/uo) and external program memory.

Parameters:
- DATA_W, 8: register/ALU/memory data width; must be >= 8; instruction and operand bytes use bits [7:0].
- REG_CNT, 8: number of general registers, 2..8.
- PC_W, 12: program counter width; PC wraps modulo 2^PC_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- halt_in  in  1  asynchronous halt request, level, active-high.
- mem_req  out  1  memory read request.
- mem_addr  out  PC_W  read address (= pc).
- mem_ack  in  1  read data valid this cycle; may be high in the same cycle as mem_req.
- mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ack.
- phase  out  3  current phase encoding.
- pc  out  PC_W  program counter.
- halted  out  1  core frozen.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- dbg_sel  in  3  debug register index.
- dbg_data  out  DATA_W  combinational: R[dbg_sel], or 0 if dbg_sel >= REG_CNT.

Behaviour:
- Reset (async, rst_n low), values held until first clk edge after release:
  - all registers, pc, flags and operand buffer cleared to 0;
  - phase = FETCH; halted = 0; halt synchroniser cleared.
- mem_req = rst_n & ~halted & (phase == FETCH or OPERAND).
- Phase encodings: FETCH 000, DECODE 001, OPERAND 010, EXEC 101, WB 110, HALTED 111.
- Instruction byte fields:
  - [7:6] N = operand bytes (0..3);
  - [5:3] op;
  - [2:0] rd.
- FETCH: hold mem_req until ack. On ack: latch instr; pc <= pc+1; go to DECODE.
- DECODE (1 cycle):
  - opcnt <= N;
  - N == 0 -> EXEC; otherwise -> OPERAND.
- OPERAND:
  - per ack: store byte Bk (k = 1..N); pc <= pc+1; opcnt--;
  - when the last byte is acked -> EXEC.
- EXEC (1 cycle). Operand b is selected by N:
  - N=0: b = R[0];
  - N=1: b = B1 zero-extended;
  - N=2: jump. pc <= {B1[7:0],B2[7:0]}[PC_W-1:0]; no ALU, no writeback, flags unchanged;
  - N=3: NOP; flags unchanged.
- ALU ops on a = R[rd], result modulo 2^DATA_W:
  - 000 ADD (c = carry out);
  - 001 SUB (c = borrow);
  - 010 AND; 011 OR; 100 XOR (c = 0 for these three);
  - 101 MOV (result = b, c unchanged);
  - 110 SHL1 (c = a msb);
  - 111 SHR1 (c = a lsb).
  - flag_z = (result == 0) for every ALU op.
- WB (1 cycle):
  - R[rd] <= result for N <= 1;
  - rd >= REG_CNT suppresses the write; reads of a nonexistent register return 0;
  - next phase FETCH.
- Latency with same-cycle ack:
  - N=0: 4 cycles per instruction; N=1: 5 cycles;
  - each ack wait stretches FETCH/OPERAND by 1 cycle.
- Halt:
  - halt_in passes through a 2-flop synchroniser (halt_s).
  - halt_s high at a phase transition edge: the next phase is stored in saved_phase; phase <= HALTED; halted = 1.
  - An outstanding req is never abandoned; halt is honoured only after its ack.
  - While halt_s stays high, state is frozen: pc, registers and flags are stable, and dbg_data stays readable.
  - halt_s falls: phase <= saved_phase on the next edge; halted = 0.
- Simultaneous events:
  - halt_s rising in the same cycle as the final ack: the ack is consumed first, then HALTED.
  - pc at 2^PC_W-1 increments to 0.
- Reset mid-operation: immediate return to the reset state; any in-flight instruction and operands are discarded.

Test Plan:
- Reset: assert rst_n low mid-OPERAND -> phase = 000, pc = 0, mem_req = 0, all R = 0; after release mem_req = 1 and mem_addr = 0.
- Immediate ADD: memory {0x41 (N=1, ADD, rd=1), 0x05}, then {0x41, 0xFB}, ack always high -> after the first instruction R1 = 5 at cycle 5; after the second R1 = 0x00, flag_z = 1, flag_c = 1, pc = 4.
- Register op, N=0: R0 = 3 loaded via MOV immediate (0x68, 0x03), then 0x01 (ADD rd=1, b = R0) -> R1 = R0+R1; EXEC-to-WB timing checked against the 4-cycle latency.
- Jump and wrap:
  - 0x80, 0x0F, 0xFF with PC_W = 12 -> pc = 0xFFF at the next FETCH;
  - an N=0 instruction at 0xFFF -> pc wraps to 0x000.
- Halt:
  - raise halt_in during DECODE -> halted = 1 within 3 cycles, phase = 111, pc frozen;
  - release -> resumes at OPERAND with no lost or duplicated operand byte.
  - Halt during a FETCH with mem_ack held low 4 cycles -> HALTED entered only after the ack.
- Parameter sweep: DATA_W = 16, REG_CNT = 4:
  - SUB 0 - 1 -> 0xFFFF with flag_c = 1;
  - write to rd = 6 is ignored; dbg_sel = 6 -> dbg_data = 0.
